// File: rtl/ahb_nmr_checker.sv
// N-modular-redundancy checker for replicated AHB peripherals: bitwise voter, persistence-filtered
// fault FSM, sticky flag, saturating fault counter and culprit mask. Optional macro: NMR_INJECT_EN.
module ahb_nmr_checker #(
  parameter int NCH     = 2,
  parameter int W       = 43,
  parameter int PERSIST = 1,
  parameter int CNT_W   = 8
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NCH*W-1:0]   ch_in,
`ifdef NMR_INJECT_EN
  input  logic [NCH*W-1:0]   inject_bug,
`endif
  input  logic               err_clr,
  output logic [W-1:0]       voted_out,
  output logic               DLS_ERROR,
  output logic               DLS_STICKY,
  output logic [NCH-1:0]     fault_ch,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_SUSPECT = 2'd1, ST_FAULT = 2'd2} state_t;

  localparam logic [3:0]       PERSIST_C = 4'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // A 2-2 tie (only possible for even NCH) resolves to channel 0; for NCH=2 this degenerates to ch0.
  function automatic logic [W-1:0] vote_f(input logic [NCH*W-1:0] v);
    logic [W-1:0] r;
    int ones;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int c = 0; c < NCH; c++) begin
        ones = ones + int'(v[c*W+b]);
      end
      if (2 * ones > NCH) begin
        r[b] = 1'b1;
      end else if (2 * ones == NCH) begin
        r[b] = v[b];
      end else begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  logic [NCH*W-1:0] ch_eff_s;
  logic [NCH-1:0]   dis_s;
  logic             mismatch_s;
  logic             entry_s;
  state_t           state_r, state_nxt_s;
  logic [3:0]       run_r, run_nxt_s;
  logic             error_r;
  logic             sticky_r;
  logic [NCH-1:0]   fault_ch_r;
  logic [CNT_W-1:0] count_r;

`ifdef NMR_INJECT_EN
  assign ch_eff_s = ch_in ^ inject_bug;
`else
  assign ch_eff_s = ch_in;
`endif

  assign voted_out = vote_f(ch_eff_s);

  // Per-channel disagreement; with two replicas both channels are blamed for any difference.
  always_comb begin
    dis_s = '0;
    if (NCH == 2) begin
      dis_s = {NCH{ch_eff_s[W +: W] != ch_eff_s[0 +: W]}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        dis_s[i] = (ch_eff_s[i*W +: W] != voted_out);
      end
    end
  end

  assign mismatch_s = |dis_s;

  // Next-state logic of the persistence filter.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    case (state_r)
      ST_OK: begin
        if (mismatch_s) begin
          if (PERSIST_C == 4'd1) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_SUSPECT;
            run_nxt_s   = 4'd1;
          end
        end else begin
          run_nxt_s = 4'd0;
        end
      end
      ST_SUSPECT: begin
        if (!mismatch_s) begin
          state_nxt_s = ST_OK;
          run_nxt_s   = 4'd0;
        end else if (run_r + 4'd1 == PERSIST_C) begin
          state_nxt_s = ST_FAULT;
          run_nxt_s   = 4'd0;
        end else begin
          run_nxt_s = run_r + 4'd1;
        end
      end
      ST_FAULT: begin
        if (mismatch_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_OK;
          run_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = ST_OK;
        run_nxt_s   = 4'd0;
      end
    endcase
  end

  assign entry_s = (state_nxt_s == ST_FAULT) && (state_r != ST_FAULT);

  // State, flags, counter and culprit mask; err_clr acts as a soft clear of the diagnostic state only.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r    <= ST_OK;
      run_r      <= 4'd0;
      error_r    <= 1'b0;
      sticky_r   <= 1'b0;
      fault_ch_r <= '0;
      count_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
      error_r <= (state_nxt_s == ST_FAULT);
      if (entry_s) begin
        sticky_r <= 1'b1;
        if (err_clr) begin
          count_r <= CNT_W'(1);
        end else if (count_r == CNT_MAX) begin
          count_r <= count_r;
        end else begin
          count_r <= count_r + CNT_W'(1);
        end
      end else if (err_clr) begin
        sticky_r <= 1'b0;
        count_r  <= '0;
      end else begin
        sticky_r <= sticky_r;
        count_r  <= count_r;
      end
      if (err_clr) begin
        fault_ch_r <= dis_s;
      end else begin
        fault_ch_r <= fault_ch_r | dis_s;
      end
    end
  end

  assign DLS_ERROR  = error_r;
  assign DLS_STICKY = sticky_r;
  assign fault_ch   = fault_ch_r;
  assign err_count  = count_r;

endmodule

// File: tb/tb_ahb_nmr_checker.sv
// Directed bench for ahb_nmr_checker: NCH=2 (CNT_W=2), NCH=3 (PERSIST=3) and NCH=4 (PERSIST=2) instances.
module tb_ahb_nmr_checker;

  localparam int W = 43;

  logic          HCLK;
  logic          HRESET;
  logic [2*W-1:0] ch2;
  logic [3*W-1:0] ch3;
  logic [4*W-1:0] ch4;
  logic          clr2, clr3, clr4;
  logic [W-1:0]  v2, v3, v4;
  logic          e2, e3, e4, s2, s3, s4;
  logic [1:0]    f2;
  logic [2:0]    f3;
  logic [3:0]    f4;
  logic [1:0]    c2;
  logic [7:0]    c3, c4;
`ifdef NMR_INJECT_EN
  logic [2*W-1:0] inj2;
  logic [3*W-1:0] inj3;
  logic [4*W-1:0] inj4;
`endif

  int checks = 0;
  int errors = 0;

  ahb_nmr_checker #(.NCH(2), .W(W), .PERSIST(1), .CNT_W(2)) u2 (
    .HCLK(HCLK), .HRESET(HRESET), .ch_in(ch2),
`ifdef NMR_INJECT_EN
    .inject_bug(inj2),
`endif
    .err_clr(clr2), .voted_out(v2), .DLS_ERROR(e2), .DLS_STICKY(s2), .fault_ch(f2), .err_count(c2));

  ahb_nmr_checker #(.NCH(3), .W(W), .PERSIST(3), .CNT_W(8)) u3 (
    .HCLK(HCLK), .HRESET(HRESET), .ch_in(ch3),
`ifdef NMR_INJECT_EN
    .inject_bug(inj3),
`endif
    .err_clr(clr3), .voted_out(v3), .DLS_ERROR(e3), .DLS_STICKY(s3), .fault_ch(f3), .err_count(c3));

  ahb_nmr_checker #(.NCH(4), .W(W), .PERSIST(2), .CNT_W(8)) u4 (
    .HCLK(HCLK), .HRESET(HRESET), .ch_in(ch4),
`ifdef NMR_INJECT_EN
    .inject_bug(inj4),
`endif
    .err_clr(clr4), .voted_out(v4), .DLS_ERROR(e4), .DLS_STICKY(s4), .fault_ch(f4), .err_count(c4));

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  logic [W-1:0] d, cr, h, a, b, c;

  initial begin
    HRESET = 1'b1;
    ch2 = '0; ch3 = '0; ch4 = '0;
    clr2 = 1'b0; clr3 = 1'b0; clr4 = 1'b0;
`ifdef NMR_INJECT_EN
    inj2 = '0; inj3 = '0; inj4 = '0;
`endif
    step();
    step();
    chk("rst_err", 64'(e2), 64'd0);
    chk("rst_sticky", 64'(s2), 64'd0);
    chk("rst_count", 64'(c2), 64'd0);
    chk("rst_fault_ch", 64'(f2), 64'd0);
    HRESET = 1'b0;

    // equal channels for 100 cycles
    d = '0;
    for (int i = 0; i < 100; i++) begin
      d = W'({$urandom, $urandom});
      ch2 = {d, d};
      step();
    end
    chk("eq_voted", 64'(v2), 64'(d));
    chk("eq_err", 64'(e2), 64'd0);
    chk("eq_sticky", 64'(s2), 64'd0);
    chk("eq_count", 64'(c2), 64'd0);
    chk("eq_fault_ch", 64'(f2), 64'd0);

    // single-cycle HRDATA bit0 flip on ch1
    d = 43'h123;
    ch2 = {d ^ 43'h1, d};
    #1;
    chk("flip_voted_ch0", 64'(v2), 64'h123);
    step();
    chk("flip_err_T1", 64'(e2), 64'd1);
    chk("flip_sticky", 64'(s2), 64'd1);
    chk("flip_count", 64'(c2), 64'd1);
    chk("flip_fault_ch", 64'(f2), 64'd3);
    ch2 = {d, d};
    step();
    chk("flip_err_T2", 64'(e2), 64'd0);
    chk("flip_sticky_hold", 64'(s2), 64'd1);

    // further separated entries saturate a 2-bit counter at 3
    for (int k = 2; k <= 4; k++) begin
      ch2 = {d ^ 43'h1, d};
      step();
      chk("sat_count", 64'(c2), (k == 2) ? 64'd2 : 64'd3);
      ch2 = {d, d};
      step();
    end

    // err_clr on an entry cycle
    ch2 = {d ^ 43'h1, d};
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("clr_entry_count", 64'(c2), 64'd1);
    chk("clr_entry_sticky", 64'(s2), 64'd1);
    chk("clr_entry_fault_ch", 64'(f2), 64'd3);
    ch2 = {d, d};
    step();

    // err_clr while staying in FAULT leaves the state alone
    h = '0; h[40] = 1'b1;
    ch2 = {d, d ^ h};
    step();
    chk("fault2_count", 64'(c2), 64'd2);
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("clr_fault_err", 64'(e2), 64'd1);
    chk("clr_fault_sticky", 64'(s2), 64'd0);
    chk("clr_fault_count", 64'(c2), 64'd0);
    chk("clr_fault_fault_ch", 64'(f2), 64'd3);
    ch2 = {d, d};
    clr2 = 1'b1;
    step();
    clr2 = 1'b0;
    chk("clr_clean_err", 64'(e2), 64'd0);
    chk("clr_clean_fault_ch", 64'(f2), 64'd0);

    // asynchronous reset while in FAULT
    ch2 = {d ^ 43'h1, d};
    step();
    chk("pre_rst_err", 64'(e2), 64'd1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("arst_err", 64'(e2), 64'd0);
    chk("arst_sticky", 64'(s2), 64'd0);
    chk("arst_count", 64'(c2), 64'd0);
    chk("arst_fault_ch", 64'(f2), 64'd0);
    ch2 = {d, d};
    step();
    HRESET = 1'b0;
    step();
    chk("post_rst_err", 64'(e2), 64'd0);

`ifdef NMR_INJECT_EN
    inj2 = '0;
    inj2[W] = 1'b1;
    step();
    chk("inject_err", 64'(e2), 64'd1);
    chk("inject_fault_ch", 64'(f2), 64'd3);
    inj2 = '0;
    step();
    chk("inject_err_clear", 64'(e2), 64'd0);
`endif

    // NCH=3, PERSIST=3: short corruption of ch2 RGB is absorbed
    cr = '0; cr[42:35] = 8'hFF;
    ch3 = {cr, 43'h0, 43'h0};
    #1;
    chk("tmr_voted_rgb", 64'(v3), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("tmr_short_err", 64'(e3), 64'd0);
    end
    chk("tmr_short_fault_ch", 64'(f3), 64'd4);
    ch3 = '0;
    step();
    chk("tmr_short_err_after", 64'(e3), 64'd0);
    chk("tmr_short_count", 64'(c3), 64'd0);

    // 5-cycle corruption: error high after 3rd..5th samples
    for (int k = 1; k <= 5; k++) begin
      ch3 = {cr, 43'h0, 43'h0};
      step();
      chk("tmr_long_err", 64'(e3), (k >= 3) ? 64'd1 : 64'd0);
    end
    ch3 = '0;
    step();
    chk("tmr_long_err_end", 64'(e3), 64'd0);
    chk("tmr_long_count", 64'(c3), 64'd1);
    chk("tmr_long_sticky", 64'(s3), 64'd1);

    // bitwise 2-of-3 with all channels different
    a = 43'h0AA; b = 43'h0CC; c = 43'h0F0;
    ch3 = {c, b, a};
    #1;
    chk("tmr_bitwise_vote", 64'(v3), 64'h0E8);
    ch3 = '0;
    step();

    // NCH=4: 2-2 tie resolved by channel 0
    h = '0; h[33] = 1'b1;
    ch4 = {43'h0, 43'h0, h, h};
    #1;
    chk("qmr_tie_ch0_one", 64'(v4), 64'(h));
    step();
    chk("qmr_tie_fault_ch", 64'(f4), 64'd12);
    chk("qmr_tie_err_p2", 64'(e4), 64'd0);
    ch4 = {h, h, 43'h0, 43'h0};
    #1;
    chk("qmr_tie_ch0_zero", 64'(v4), 64'd0);
    step();
    chk("qmr_persist2_err", 64'(e4), 64'd1);
    chk("qmr_persist2_count", 64'(c4), 64'd1);

    // 3-1 majority with err_clr: mask restarts with this cycle's culprit
    a = 43'h080;
    ch4 = {a, a, a, 43'h0};
    clr4 = 1'b1;
    #1;
    chk("qmr_3of4_vote", 64'(v4), 64'h080);
    step();
    clr4 = 1'b0;
    chk("qmr_clr_fault_ch", 64'(f4), 64'd1);
    ch4 = {a, 43'h0, 43'h0, 43'h0};
    #1;
    chk("qmr_1of4_vote", 64'(v4), 64'd0);
    ch4 = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
